// File: rtl/uart_echo_fifo.sv
// UART loopback: 2-flop RXD sync, parametrised RX/TX framers, FWFT word FIFO between them.
// Latency: TXD start bit begins on the 2nd rising edge after the rx_valid cycle (FIFO empty, TX idle).
// Backpressure: tx_enable gates only new TX frames; a good word arriving with the FIFO full is dropped and flagged.
module uart_echo_fifo #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RXD,
    input  logic                 tx_enable,
    output logic                 TXD,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overflow,
    output logic [FIFO_AW:0]     fifo_count
);
    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int HALF  = (CPB / 2 > 0) ? CPB / 2 : 1;
    localparam int CW    = $clog2(CPB + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0]    CPB_M1    = CW'(CPB - 1);
    localparam logic [CW-1:0]    HALF_M1   = CW'(HALF - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Parity of a word: even mode is the XOR of the bits, odd mode its inverse.
    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : ^d;
    endfunction

    logic rxd_s1, rxd_s2, rxd_prev;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= RXD;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    // ---------------- receiver ----------------
    state_t                rx_state_q, rx_state_d;
    logic [CW-1:0]         rx_cnt;
    logic [3:0]            rx_bit;
    logic                  rx_tick, rx_last;
    logic [DATA_BITS-1:0]  rx_shreg;
    logic                  rx_par_bit, rx_stop_bad, push_q;
    logic                  frame_bad, parity_bad, word_good;
    logic                  fifo_full, fifo_empty, push, pop;

    // RX next state: start is qualified at half a bit, all later samples one bit apart.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick    = 1'b0;
        rx_last    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rxd_prev && !rxd_s2) rx_state_d = S_START;
            end
            S_START: begin
                rx_tick = (rx_cnt == HALF_M1);
                if (rx_tick) rx_state_d = rxd_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                rx_tick = (rx_cnt == CPB_M1);
                if (rx_tick && rx_bit == DATA_LAST)
                    rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                rx_tick = (rx_cnt == CPB_M1);
                if (rx_tick) rx_state_d = S_STOP;
            end
            S_STOP: begin
                rx_tick = (rx_cnt == CPB_M1);
                if (rx_tick && rx_bit == STOP_LAST) begin
                    rx_last    = 1'b1;
                    rx_state_d = S_IDLE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // End-of-frame verdict; framing error outranks parity error.
    always_comb begin
        frame_bad  = rx_stop_bad | ~rxd_s2;
        parity_bad = (PARITY != 0) && (rx_par_bit != par_of(rx_shreg));
        word_good  = !frame_bad && !parity_bad;
    end

    // RX state, bit timing, shift register and the registered one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q  <= S_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shreg    <= '0;
            rx_par_bit  <= 1'b0;
            rx_stop_bad <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overflow    <= 1'b0;
            push_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt     <= (rx_state_q == S_IDLE || rx_tick) ? '0 : rx_cnt + CW'(1);
            rx_bit     <= (rx_state_d != rx_state_q) ? '0 : rx_bit + 4'(rx_tick);
            if (rx_tick && rx_state_q == S_DATA)
                rx_shreg <= {rxd_s2, rx_shreg[DATA_BITS-1:1]};
            if (rx_tick && rx_state_q == S_PARITY)
                rx_par_bit <= rxd_s2;
            if (rx_state_q == S_START)
                rx_stop_bad <= 1'b0;
            else if (rx_tick && rx_state_q == S_STOP)
                rx_stop_bad <= rx_stop_bad | ~rxd_s2;
            rx_valid   <= rx_last && word_good;
            frame_err  <= rx_last && frame_bad;
            parity_err <= rx_last && !frame_bad && parity_bad;
            overflow   <= rx_last && word_good && fifo_full;
            // The write lands one cycle after the verdict, from the updated rx_data.
            push_q     <= rx_last && word_good && !fifo_full;
            if (rx_last && word_good)
                rx_data <= rx_shreg;
        end
    end

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count;
    logic [DATA_BITS-1:0] head;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign push       = push_q && !fifo_full;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    // Pointers wrap naturally; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        end
    end

    // ---------------- transmitter ----------------
    state_t               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
    logic                 tx_par_q, tx_par_d, txd_d, tx_tick, tx_go;

    // TX next state; the last stop bit chains straight into the next start bit when a word waits.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shreg_d = tx_shreg_q;
        tx_par_d   = tx_par_q;
        pop        = 1'b0;
        tx_go      = !fifo_empty && tx_enable;
        tx_tick    = (tx_cnt == CPB_M1);
        case (tx_state_q)
            S_IDLE: begin
                if (tx_go) begin
                    tx_state_d = S_START;
                    pop        = 1'b1;
                end
            end
            S_START: begin
                if (tx_tick) tx_state_d = S_DATA;
            end
            S_DATA: begin
                if (tx_tick) begin
                    if (tx_bit == DATA_LAST)
                        tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else
                        tx_shreg_d = tx_shreg_q >> 1;
                end
            end
            S_PARITY: begin
                if (tx_tick) tx_state_d = S_STOP;
            end
            S_STOP: begin
                if (tx_tick && tx_bit == STOP_LAST) begin
                    tx_state_d = tx_go ? S_START : S_IDLE;
                    pop        = tx_go;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (pop) begin
            tx_shreg_d = head;
            tx_par_d   = par_of(head);
        end
        case (tx_state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = tx_shreg_d[0];
            S_PARITY: txd_d = tx_par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    // TX registers; TXD is registered so the line is glitch-free and high from the first reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shreg_q <= '0;
            tx_par_q   <= 1'b0;
            TXD        <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt     <= (tx_state_q == S_IDLE || tx_tick) ? '0 : tx_cnt + CW'(1);
            tx_bit     <= (tx_state_d != tx_state_q) ? '0 : tx_bit + 4'(tx_tick);
            tx_shreg_q <= tx_shreg_d;
            tx_par_q   <= tx_par_d;
            TXD        <= txd_d;
        end
    end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo at 16 clocks per bit, 8 data bits, even parity, 1 stop bit, 16-deep FIFO.
// A line monitor decodes TXD frames; a reference model predicts words and status pulses per frame.
// Directed scenarios plus a randomised burst, all checked with immediate assertions.
module tb_uart_echo_fifo;
    localparam int CPB = 16;
    localparam int FRAME = 11 * CPB;

    logic       clk = 1'b0;
    logic       reset, RXD, tx_enable;
    logic       TXD, rx_valid, frame_err, parity_err, overflow;
    logic [7:0] rx_data;
    logic [4:0] fifo_count;

    uart_echo_fifo #(
        .CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_AW(4)
    ) dut (
        .clk(clk), .reset(reset), .RXD(RXD), .tx_enable(tx_enable),
        .TXD(TXD), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_err(frame_err), .parity_err(parity_err),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int n_rv = 0, n_fe = 0, n_pe = 0, n_ov = 0, rv_cyc = 0, low_cnt = 0;
    int exp_rv = 0, exp_fe = 0, exp_pe = 0, exp_ov = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       st;
        logic       sp;
        int         sc;
    } txf_t;

    txf_t       tx_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin n_rv++; rv_cyc = cyc; end
        if (frame_err === 1'b1) n_fe++;
        if (parity_err === 1'b1) n_pe++;
        if (overflow === 1'b1) n_ov++;
        if (TXD !== 1'b1) low_cnt++;
    end

    // TXD line decoder: mid-bit sampling from the detected start edge.
    initial begin : mon
        logic mprev;
        txf_t f;
        mprev = 1'b1;
        forever begin
            @(negedge clk);
            if (mprev && TXD === 1'b0) begin
                f.sc = cyc;
                repeat (CPB / 2 - 1) @(negedge clk);
                f.st = TXD;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    f.d[i] = TXD;
                end
                repeat (CPB) @(negedge clk);
                f.p = TXD;
                repeat (CPB) @(negedge clk);
                f.sp = TXD;
                tx_q.push_back(f);
            end
            mprev = TXD;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame on RXD, negedge aligned; returns at a negedge.
    task automatic send(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        RXD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RXD = d[i];
            repeat (CPB) @(negedge clk);
        end
        RXD = (^d) ^ bad_par;
        repeat (CPB) @(negedge clk);
        RXD = !bad_stop;
        repeat (CPB) @(negedge clk);
        RXD = 1'b1;
        if (bad_stop) repeat (CPB) @(negedge clk);
    endtask

    // Reference outcome of one frame while TX drains freely.
    task automatic model(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        if (bad_stop) exp_fe++;
        else if (bad_par) exp_pe++;
        else begin
            exp_rv++;
            exp_q.push_back(d);
        end
    endtask

    task automatic send_m(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send(d, bad_par, bad_stop);
        model(d, bad_par, bad_stop);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (tx_q.size() < n && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(tx_q.size() >= n), 32'd1);
    endtask

    task automatic check_frames(input string tag);
        txf_t f;
        logic [7:0] e;
        while (tx_q.size() > 0 && exp_q.size() > 0) begin
            f = tx_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(f.d), 32'(e));
            chk({tag, "_par"}, 32'(f.p), 32'(^e));
            chk({tag, "_start"}, 32'(f.st), 32'd0);
            chk({tag, "_stop"}, 32'(f.sp), 32'd1);
        end
        chk({tag, "_extra_tx"}, 32'(tx_q.size()), 32'd0);
        chk({tag, "_missing_tx"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_rv"}, 32'(n_rv), 32'(exp_rv));
        chk({tag, "_fe"}, 32'(n_fe), 32'(exp_fe));
        chk({tag, "_pe"}, 32'(n_pe), 32'(exp_pe));
        chk({tag, "_ov"}, 32'(n_ov), 32'(exp_ov));
    endtask

    initial begin : main
        int l0, k;
        logic bp, bs;
        reset = 1'b1;
        RXD = 1'b1;
        tx_enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(TXD), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single word: echo, latency and held rx_data.
        send_m(8'h55, 1'b0, 1'b0);
        wait_tx(1, "a_timeout");
        if (tx_q.size() > 0) chk("a_latency", 32'(tx_q[0].sc - rv_cyc), 32'd2);
        chk("a_rx_data", 32'(rx_data), 32'h55);
        check_frames("a");
        chk("a_fifo_count", 32'(fifo_count), 32'd0);
        check_counts("a");

        // Two words separated by idle, echoed in order.
        send_m(8'h7D, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        send_m(8'h55, 1'b0, 1'b0);
        wait_tx(2, "b_timeout");
        check_frames("b");
        check_counts("b");

        // Glitch shorter than half a bit: nothing happens, then a real word.
        l0 = low_cnt;
        RXD = 1'b0;
        repeat (5) @(negedge clk);
        RXD = 1'b1;
        repeat (40) @(negedge clk);
        chk("c_txd_quiet", 32'(low_cnt - l0), 32'd0);
        check_counts("c_glitch");
        send_m(8'h55, 1'b0, 1'b0);
        wait_tx(1, "c_timeout");
        check_frames("c");

        // Framing error, and framing error outranking a parity error.
        l0 = low_cnt;
        send_m(8'hA3, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("d_fifo_count", 32'(fifo_count), 32'd0);
        check_counts("d_stop");
        send_m(8'h3C, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check_counts("d_both");
        chk("d_no_tx", 32'(low_cnt - l0), 32'd0);

        // Parity error dropped; the corrected resend echoes with parity bit 1.
        send_m(8'h07, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check_counts("e_bad");
        chk("e_no_tx", 32'(tx_q.size()), 32'd0);
        send_m(8'h07, 1'b0, 1'b0);
        wait_tx(1, "e_timeout");
        check_frames("e");

        // Randomised back-to-back burst with occasional parity/framing faults.
        for (int i = 0; i < 12; i++) begin
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 3) == 0);
            send_m(8'($urandom), bp, bs);
        end
        wait_tx(exp_q.size(), "f_timeout");
        check_frames("f");
        repeat (CPB) @(negedge clk);
        check_counts("f");

        // TX held off: 16 words fill the FIFO, the 17th overflows, then drain in order.
        tx_enable = 1'b0;
        for (int w = 0; w < 17; w++) begin
            send(8'(w), 1'b0, 1'b0);
            exp_rv++;
            if (w < 16) exp_q.push_back(8'(w));
            else exp_ov++;
            if (w == 15) begin
                chk("g_count_16", 32'(fifo_count), 32'd16);
                check_counts("g_before_ov");
            end
        end
        repeat (4) @(negedge clk);
        chk("g_count_full", 32'(fifo_count), 32'd16);
        chk("g_no_tx", 32'(tx_q.size()), 32'd0);
        check_counts("g_after_ov");
        tx_enable = 1'b1;
        wait_tx(16, "g_timeout");
        for (int i = 1; i < 16 && i < tx_q.size(); i++)
            chk("g_spacing", 32'(tx_q[i].sc - tx_q[i - 1].sc), 32'(FRAME));
        check_frames("g");
        chk("g_count_empty", 32'(fifo_count), 32'd0);

        // Reset in the middle of a TX frame with a second word still queued.
        tx_enable = 1'b0;
        send(8'h81, 1'b0, 1'b0);
        send(8'h18, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("h_count_2", 32'(fifo_count), 32'd2);
        tx_enable = 1'b1;
        k = 0;
        while (TXD !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("h_tx_started", 32'(TXD), 32'd0);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("h_rst_txd", 32'(TXD), 32'd1);
        chk("h_rst_count", 32'(fifo_count), 32'd0);
        reset = 1'b0;
        l0 = low_cnt;
        repeat (400) @(negedge clk);
        chk("h_txd_quiet", 32'(low_cnt - l0), 32'd0);
        chk("h_count_after", 32'(fifo_count), 32'd0);
        tx_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Parametrised UART loopback: receives serial frames on RXD, buffers good words in a FIFO, retransmits them on TXD.
- Successor to the fixed 8N1/9600 echo block. Adds configurable data width, parity and stop bits, FIFO buffering, TX flow control and error/status reporting.
- Sits between the board UART pins and the host-facing status logic.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (10416 at defaults)
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16)

Ports:
clk  in  1  system clock; sole clock, all logic on its rising edge
reset  in  1  synchronous, active-high reset
RXD  in  1  asynchronous serial input, idle high
tx_enable  in  1  1 = TX may start a new frame (CTS-style flow control)
TXD  out  1  serial output, idle high
rx_valid  out  1  1-cycle pulse: good word received
rx_data  out  DATA_BITS  last good word; valid when rx_valid=1, held otherwise
frame_err  out  1  1-cycle pulse: stop bit sampled low
parity_err  out  1  1-cycle pulse: parity mismatch (PARITY!=0 only)
overflow  out  1  1-cycle pulse: good word dropped because FIFO full
fifo_count  out  FIFO_AW+1  words currently buffered, 0..2**FIFO_AW

Behaviour:
- Reset values: TXD=1, rx_valid=0, rx_data=0, frame_err=0, parity_err=0, overflow=0, fifo_count=0. Both FSMs go to IDLE and the FIFO is emptied.
- Reset mid-frame aborts both directions. TXD is high from the first edge with reset=1.
- RXD passes through a 2-flop synchroniser before any use. This adds 2 cycles of latency.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised falling edge.
  - START: sample at CLKS_PER_BIT/2. If the sample is high, the start was false (glitch): return to IDLE with no pulse. If low, go to DATA.
  - DATA: DATA_BITS samples, each CLKS_PER_BIT apart, shifted in LSB first.
  - PARITY: present only if PARITY!=0. One sample is compared with the computed parity.
  - STOP: STOP_BITS samples. Any low sample flags a framing error.
- End-of-frame decision is made one cycle after the final stop-bit sample, with these priorities:
  - Framing error: frame_err pulses, the word is dropped, and parity_err is suppressed.
  - Parity error (no framing error): parity_err pulses and the word is dropped.
  - Good word: rx_valid pulses and rx_data is updated. If fifo_count < depth the word is written to the FIFO. If the FIFO is full, overflow pulses alongside rx_valid and the word is not stored.
- After the decision the RX FSM returns to IDLE. It is ready for a new start edge immediately; no idle gap is required.
- The FIFO is synchronous and first-word-fall-through.
  - Push and pop in the same cycle: fifo_count is unchanged.
  - When full, a push is dropped even if a pop happens in the same cycle.
  - Pointers wrap modulo 2**FIFO_AW.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when FIFO is non-empty and tx_enable=1. The word is popped on this transition.
  - Each bit lasts exactly CLKS_PER_BIT cycles. Order on the line: start bit 0, data LSB first, parity bit if enabled, STOP_BITS stop bits of 1.
  - Return to IDLE after the last stop bit. Back-to-back frames have no extra idle cycles.
- tx_enable is sampled only in TX IDLE. Deasserting it mid-frame does not truncate the frame.
- TX latency: with the FIFO empty, TX idle and tx_enable=1, TXD goes low on the 2nd rising edge after the cycle in which rx_valid=1.
- Parity bit: even = XOR of the data bits; odd = inverted XOR.

Test Plan:
- Default params. After reset release, send 0x55 (LSB first 1,0,1,0,1,0,1,0) at 104 us/bit -> rx_valid pulse with rx_data=0x55. TXD replays start, 0x55, stop with each bit 10416 clk wide. fifo_count returns to 0.
- Send 0x7D (bits 1,0,1,1,1,1,1,0), then 3 ms idle, then 0x55 -> two echoed frames in order (0x7D, 0x55). No error pulses.
- Drive RXD low for 20 us then high (false start) -> no rx_valid, no error pulse, TXD stays high, FSM re-arms for a valid 0x55 sent afterwards.
- Send 0xA3 with the stop bit driven low -> frame_err pulses once, no rx_valid, fifo_count stays 0, no TX activity.
- PARITY=2: send 0x07 with parity bit 0 -> parity_err pulses and nothing is echoed. Resend with parity bit 1 -> 0x07 is echoed with parity bit 1.
- tx_enable=0: send 17 words 0x00..0x10 -> fifo_count reaches 16 and overflow pulses on word 0x10. Then set tx_enable=1 -> TXD emits 0x00..0x0F in order and fifo_count returns to 0.
- Assert reset for 1 cycle mid-TX frame -> TXD is 1 from that edge, fifo_count=0, no further TX output.
